// File: rtl/if_fetch_if.sv
// Instruction-memory bus of the fetch stage.
// Handshake: while imem_req is 1, imem_addr holds steady; the first cycle
// with imem_ready = 1 completes the access and imem_data is valid in that
// cycle only. imem_ready is ignored while imem_req is 0.
interface if_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;

   modport master (output imem_req, output imem_addr,
                   input  imem_ready, input imem_data);
   modport slave  (input  imem_req, input imem_addr,
                   output imem_ready, output imem_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, feeds IF/ID.
// Handles hazard stalls (PCWrite) and branch/jump redirects, discarding any
// wrong-path access still in flight.
// Optional build macro IF_FLUSH_NOP_EN: a redirect also forces instrucao to
// NOP and PC4 to 0 (otherwise only fetch_valid is cleared).
// dbg_state exposes the FSM state: 0 IDLE, 1 WAIT, 2 HOLD, 3 DROP.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        PCWrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] addressJump,
   input  logic [31:0] PC4_id,
   if_fetch_if.master  imem,
   output logic [31:0] instrucao,
   output logic [31:0] PC4,
   output logic        fetch_valid,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2, S_DROP = 2'd3} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;
   logic [31:0] hold_data, hold_data_n;
   logic [31:0] instrucao_n, pc4_n;
   logic        fetch_valid_n;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] req_next;
   logic        unused_bits;

   // Branch is older than the jump in IF/ID, so it wins when both fire.
   assign redirect = branch_taken | jump;
   assign target   = branch_taken ? {branch_target[31:2], 2'b00}
                                  : {PC4_id[31:28], addressJump, 2'b00};
   assign req_next = req_addr + 32'd4;
   assign unused_bits = ^{branch_target[1:0], PC4_id[27:0]};

   // Request is a pure function of state so reset drops it asynchronously.
   assign imem.imem_req  = (state == S_WAIT) || (state == S_DROP);
   assign imem.imem_addr = req_addr;
   assign dbg_state      = state;

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         hold_data   <= 32'd0;
         instrucao   <= NOP;
         PC4         <= 32'd0;
         fetch_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_addr    <= req_addr_n;
         hold_data   <= hold_data_n;
         instrucao   <= instrucao_n;
         PC4         <= pc4_n;
         fetch_valid <= fetch_valid_n;
      end
   end

   // Next-state and next-datapath values.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      req_addr_n    = req_addr;
      hold_data_n   = hold_data;
      instrucao_n   = instrucao;
      pc4_n         = PC4;
      fetch_valid_n = fetch_valid;

      if (redirect) begin
         pc_n          = target;
         fetch_valid_n = 1'b0;
`ifdef IF_FLUSH_NOP_EN
         instrucao_n   = NOP;
         pc4_n         = 32'd0;
`endif
         case (state)
            S_IDLE: begin
               state_n    = S_WAIT;
               req_addr_n = target;
            end
            S_WAIT, S_DROP: begin
               // An access cannot be cancelled: if it is still open, wait
               // it out in DROP and issue the target afterwards.
               if (imem.imem_ready) begin
                  state_n    = S_WAIT;
                  req_addr_n = target;
               end else begin
                  state_n    = S_DROP;
               end
            end
            default: begin
               state_n    = S_WAIT;
               req_addr_n = target;
            end
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               state_n    = S_WAIT;
               req_addr_n = pc;
            end
            S_WAIT: begin
               if (imem.imem_ready) begin
                  if (PCWrite) begin
                     instrucao_n   = imem.imem_data;
                     pc4_n         = req_next;
                     fetch_valid_n = 1'b1;
                     pc_n          = req_next;
                     req_addr_n    = req_next;
                  end else begin
                     hold_data_n = imem.imem_data;
                     state_n     = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (PCWrite) begin
                  instrucao_n   = hold_data;
                  pc4_n         = req_next;
                  fetch_valid_n = 1'b1;
                  pc_n          = req_next;
                  req_addr_n    = req_next;
                  state_n       = S_WAIT;
               end
            end
            default: begin
               if (imem.imem_ready) begin
                  req_addr_n = pc;
                  state_n    = S_WAIT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed walk through the main scenarios, then random
// stimulus, checked every cycle against a queue-based reference model.
// A second instance with RESET_PC = 32'hFFFF_FFFC checks address wrap.
module tb_if_fetch;

   localparam logic [31:0] NOP_W = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT 0 ----------------
   logic        pw, rdy, br, jp;
   logic [31:0] bt, pc4id;
   logic [25:0] aj;
   logic [31:0] instr, pc4;
   logic        fv;
   logic [1:0]  dbg0;
   if_fetch_if bus0 ();

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   assign bus0.imem_ready = rdy;
   assign bus0.imem_data  = mem_word(bus0.imem_addr);

   if_fetch #(.RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut (
      .clock(clock), .reset_n(reset_n), .PCWrite(pw),
      .branch_taken(br), .branch_target(bt), .jump(jp),
      .addressJump(aj), .PC4_id(pc4id), .imem(bus0.master),
      .instrucao(instr), .PC4(pc4), .fetch_valid(fv), .dbg_state(dbg0));

   // ---------------- DUT 1 (wrap) ----------------
   logic [31:0] instr1, pc4_1;
   logic        fv1;
   logic [1:0]  dbg1;
   if_fetch_if bus1 ();
   assign bus1.imem_ready = 1'b1;
   assign bus1.imem_data  = mem_word(bus1.imem_addr);

   if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP(NOP_W)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .PCWrite(1'b1),
      .branch_taken(1'b0), .branch_target(32'd0), .jump(1'b0),
      .addressJump(26'd0), .PC4_id(32'd0), .imem(bus1.master),
      .instrucao(instr1), .PC4(pc4_1), .fetch_valid(fv1), .dbg_state(dbg1));

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: exp_q holds addresses of accesses in flight (wrong_q
   // marks ones a redirect has orphaned); park_q holds a word completed while
   // the pipeline was stalled.
   logic [31:0] exp_q[$];
   bit          wrong_q[$];
   logic [31:0] park_q[$];
   logic [31:0] park_addr;
   bit          m_started;
   logic [31:0] m_pc, m_instr, m_pc4;
   bit          m_fv;

   task automatic model_reset();
      exp_q.delete(); wrong_q.delete(); park_q.delete();
      m_started = 0; m_pc = 32'd0; park_addr = 32'd0;
      m_instr = NOP_W; m_pc4 = 32'd0; m_fv = 0;
   endtask

   task automatic model_flush();
      m_fv = 0;
`ifdef IF_FLUSH_NOP_EN
      m_instr = NOP_W;
      m_pc4   = 32'd0;
`endif
   endtask

   task automatic issue(input logic [31:0] a);
      exp_q.push_back(a);
      wrong_q.push_back(1'b0);
   endtask

   task automatic deliver(input logic [31:0] w, input logic [31:0] a);
      m_instr = w; m_pc4 = a + 32'd4; m_fv = 1;
      m_pc = a + 32'd4;
      issue(m_pc);
   endtask

   task automatic model_edge(input bit w, input bit r, input bit b, input logic [31:0] t,
                             input bit j, input logic [25:0] a, input logic [31:0] p);
      bit          redir;
      logic [31:0] tgt, acc;
      bit          wr;
      redir = b | j;
      tgt   = b ? {t[31:2], 2'b00} : {p[31:28], a, 2'b00};
      if (!m_started) begin
         m_started = 1;
         if (redir) begin m_pc = tgt; model_flush(); end
         issue(m_pc);
      end else if (exp_q.size() != 0) begin
         acc = exp_q[0];
         wr  = wrong_q[0];
         if (redir) begin
            m_pc = tgt; model_flush();
            if (r) begin
               void'(exp_q.pop_front()); void'(wrong_q.pop_front());
               issue(tgt);
            end else begin
               wrong_q[0] = 1'b1;
            end
         end else if (r) begin
            void'(exp_q.pop_front()); void'(wrong_q.pop_front());
            if (wr) issue(m_pc);
            else if (w) deliver(mem_word(acc), acc);
            else begin park_q.push_back(mem_word(acc)); park_addr = acc; end
         end
      end else begin
         if (redir) begin
            park_q.delete(); m_pc = tgt; model_flush(); issue(tgt);
         end else if (w) begin
            deliver(park_q.pop_front(), park_addr);
         end
      end
   endtask

   task automatic compare();
      check("imem_req", {31'd0, bus0.imem_req}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("imem_addr", bus0.imem_addr, exp_q[0]);
      check("instrucao", instr, m_instr);
      check("PC4", pc4, m_pc4);
      check("fetch_valid", {31'd0, fv}, {31'd0, m_fv});
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit w, input bit r, input bit b, input logic [31:0] t,
                       input bit j, input logic [25:0] a, input logic [31:0] p);
      pw = w; rdy = r; br = b; bt = t; jp = j; aj = a; pc4id = p;
      @(posedge clock);
      model_edge(w, r, b, t, j, a, p);
      #1;
      compare();
   endtask

   task automatic run(input bit w, input bit r);
      step(w, r, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
   endtask

   // Wrap instance: second fetch address is 0 and first PC4 is 0.
   initial begin
      @(posedge reset_n);
      @(posedge clock); #1;
      check("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
      @(posedge clock); #1;
      check("wrap_addr1", bus1.imem_addr, 32'h0000_0000);
      check("wrap_instr", instr1, 32'h3FFF_FFFF);
      check("wrap_PC4", pc4_1, 32'h0000_0000);
      check("wrap_fv", {31'd0, fv1}, 32'd1);
   end

   // ---------------- main sequence ----------------
   initial begin
      pw = 1; rdy = 1; br = 0; jp = 0; bt = 0; aj = 0; pc4id = 0;
      model_reset();
      #12;
      compare();
      check("rst_addr", bus0.imem_addr, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // streaming: addresses 0,4 complete back-to-back
      run(1, 1); run(1, 1); run(1, 1);
      check("stream_instr1", instr, 32'd1);
      // memory wait on address 8
      run(1, 0); run(1, 0); run(1, 0);
      check("wait_addr8", bus0.imem_addr, 32'd8);
      run(1, 1);
      check("wait_instr2", instr, 32'd2);
      // stall while 12 completes, then release
      run(0, 1); run(0, 1);
      check("hold_req", {31'd0, bus0.imem_req}, 32'd0);
      run(1, 1);
      check("hold_instr3", instr, 32'd3);
      check("hold_PC4", pc4, 32'd16);
      check("hold_addr16", bus0.imem_addr, 32'd16);
      run(1, 1);
      // branch to 0x103 while the access to 20 is stalled
      step(1, 0, 1, 32'h0000_0103, 0, 26'd0, 32'd0);
      run(1, 0);
      run(1, 1);
      check("drop_addr", bus0.imem_addr, 32'h0000_0100);
      run(1, 1);
      // branch and jump together: branch wins
      step(1, 1, 1, 32'h0000_0040, 1, 26'h3FF_FFFF, 32'hA000_0000);
      check("prio_addr", bus0.imem_addr, 32'h0000_0040);
      run(1, 1);
      // jump alone
      step(1, 1, 0, 32'd0, 1, 26'h3FF_FFFF, 32'hA000_0000);
      check("jump_addr", bus0.imem_addr, 32'hAFFF_FFFC);
      run(1, 1); run(1, 1);

      // random stimulus
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 11) == 0, $urandom(),
              $urandom_range(0, 11) == 0, 26'($urandom()), $urandom());
      end

      // asynchronous reset with an access outstanding
      run(1, 0); run(1, 0);
      check("pre_rst_req", {31'd0, bus0.imem_req}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare();
      check("arst_addr", bus0.imem_addr, 32'd0);
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the IF/ID register: it owns the program counter and runs a req/ready handshake with instruction memory. Each cycle it presents the fetched word (`instrucao`) and its PC+4 (`PC4`) to IF/ID. It applies hazard stalls (`PCWrite`) and redirects from taken branches and jumps, and discards any wrong-path fetch still in flight.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `NOP`, default 32'h0000_0000: word driven on `instrucao` at reset and on flush.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `PCWrite`  in  1  1 = advance, 0 = stall (hold PC and outputs)
- `branch_taken`  in  1  taken branch resolved this cycle
- `branch_target`  in  32  branch target address
- `jump`  in  1  jump decoded this cycle
- `addressJump`  in  26  jump field from IF/ID
- `PC4_id`  in  32  PC+4 of the jump instruction, from IF/ID
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_ready`  in  1  access completes this cycle; data is valid
- `imem_data`  in  32  instruction word
- `instrucao`  out  32  instruction to IF/ID
- `PC4`  out  32  PC+4 of `instrucao`
- `fetch_valid`  out  1  `instrucao` is a valid in-path instruction

## Operation
- Internal registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the outstanding access; drives `imem_addr`.
  - `hold_data`: parks one completed word.
- States:
  - IDLE: post-reset.
  - WAIT: request outstanding.
  - HOLD: word parked because of a stall.
  - DROP: wrong-path request outstanding.
- `imem_req` = 1 in WAIT and DROP only.
- Handshake: while `imem_req`=1, `imem_addr` is stable until a cycle with `imem_ready`=1. That cycle is the completion.
- Redirect target:
  - `branch_taken`: {`branch_target`[31:2], 2'b00}.
  - Else `jump`: {`PC4_id`[31:28], `addressJump`, 2'b00}.
  - When both are asserted, the branch wins (it is the older instruction).
- A redirect overrides `PCWrite`=0. It always sets `pc` ← target and `fetch_valid` ← 0.
- Transitions when no redirect is asserted:
  - IDLE → WAIT; `req_addr` ← `pc`.
  - WAIT, completion, `PCWrite`=1: `instrucao` ← `imem_data`; `PC4` ← `req_addr`+4; `fetch_valid` ← 1. Then `pc`, `req_addr` ← `req_addr`+4, and stay in WAIT (back-to-back issue).
  - WAIT, completion, `PCWrite`=0: `hold_data` ← `imem_data` → HOLD. Outputs unchanged.
  - WAIT, no completion: stay in WAIT.
  - HOLD, `PCWrite`=1: outputs ← `hold_data`, `req_addr`+4, 1. Issue `req_addr`+4 → WAIT.
  - HOLD, `PCWrite`=0: stay in HOLD.
  - DROP, completion: discard the word. `req_addr` ← `pc` → WAIT.
- Transitions when a redirect is asserted:
  - WAIT without completion → DROP.
  - WAIT with completion → WAIT; the word is discarded; `req_addr` ← target.
  - HOLD → WAIT; `hold_data` is discarded; `req_addr` ← target.
  - DROP: stay in DROP with the updated `pc`. A completion in that same cycle → WAIT at the target.
- Arithmetic: 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset, asynchronous:
  - `pc` = `req_addr` = `RESET_PC`; state IDLE; `imem_req` = 0.
  - `instrucao` = `NOP`; `PC4` = 0; `fetch_valid` = 0; `hold_data` = 0.
- With `imem_ready` tied to 1:
  - First request is visible after the 1st edge following `reset_n` release.
  - First valid instruction appears after the 2nd edge.
  - Throughput is then 1 instruction/cycle.
- Fetch latency is 1 edge after completion. `imem_addr` is registered.
- Redirect: the target request is visible 1 edge after the redirect, unless in DROP. From DROP it is issued 1 edge after the old access completes.
- Stall: outputs hold on every edge where `PCWrite`=0 and no redirect is asserted.
- Reset asserted mid-access: the outstanding access is abandoned immediately and `imem_req` drops asynchronously.

## Configuration
- `IF_FLUSH_NOP_EN` defined: on a redirect, `instrucao` ← `NOP` and `PC4` ← 0 in addition to `fetch_valid` ← 0.
- `IF_FLUSH_NOP_EN` undefined: on a redirect, only `fetch_valid` ← 0. `instrucao` and `PC4` retain their previous values.

## Test plan
- Reset, `imem_ready`=1, memory word[i] = i: `imem_addr` 0,4,8,…; `fetch_valid`=1 from the 2nd edge; `instrucao`=0,1,2 with `PC4`=4,8,12.
- `imem_ready` low 3 cycles on addr 8: `imem_req` and `imem_addr`=8 stay stable; `instrucao`=2 appears only after the completing edge.
- `PCWrite`=0 for 2 cycles while addr 12 completes: outputs frozen; `imem_req`=0 in HOLD. After release, `instrucao`=3, `PC4`=16, next `imem_addr`=16.
- `branch_taken`=1, `branch_target`=32'h0000_0103, with the access to 20 stalled by `imem_ready`=0: DROP; the word from 20 is never output; the next request goes to 32'h100. With `IF_FLUSH_NOP_EN`, `instrucao`=0 and `PC4`=0 during the flush.
- `jump`=1 with `addressJump`=26'h3FF_FFFF and `PC4_id`=32'hA000_0000 in the same cycle as `branch_taken`=1 with target 32'h40: the next `imem_addr`=32'h40 (branch priority).
- `RESET_PC`=32'hFFFF_FFFC, `imem_ready`=1: the second fetch address is 0; `PC4`=0 on the first instruction.
